// File: rtl/gpu_cmd_queue_if.sv
// CPU-side command push bus: one command per valid&&ready beat, fields qualified by cmd_valid.
interface gpu_cmd_queue_if #(
    parameter int XW = 11,
    parameter int YW = 10
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [31:0]   cmd_address;
    logic [15:0]   cmd_address_x;
    logic [15:0]   cmd_address_y;
    logic [15:0]   cmd_image_width;
    logic [XW-1:0] cmd_width;
    logic [YW-1:0] cmd_height;
    logic [XW-1:0] cmd_x;
    logic [YW-1:0] cmd_y;
    logic [15:0]   cmd_color;

    modport master (
        output cmd_valid, cmd_op, cmd_address, cmd_address_x, cmd_address_y,
               cmd_image_width, cmd_width, cmd_height, cmd_x, cmd_y, cmd_color,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_address, cmd_address_x, cmd_address_y,
               cmd_image_width, cmd_width, cmd_height, cmd_x, cmd_y, cmd_color,
        output cmd_ready
    );
endinterface

// File: rtl/gpu_cmd_queue.sv
// Command FIFO + sequencer feeding the GPU: push-to-strobe 2 cycles, cmd_ready drops only when full.
// Optional GPU_CMDQ_STATS_EN adds stat_cmds / stat_full counters.
module gpu_cmd_queue #(
    parameter int DEPTH     = 8,
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240,
    parameter int XW        = $clog2(FB_WIDTH) + 2,
    parameter int YW        = $clog2(FB_HEIGHT) + 2
) (
    input  logic                     clk,
    input  logic                     reset,
    gpu_cmd_queue_if.slave           cmd,
    output logic                     gpu_enable,
    output logic [31:0]              ctrl_address,
    output logic [15:0]              ctrl_address_x,
    output logic [15:0]              ctrl_address_y,
    output logic [15:0]              ctrl_image_width,
    output logic [XW-1:0]            ctrl_width,
    output logic [YW-1:0]            ctrl_height,
    output logic [XW-1:0]            ctrl_x,
    output logic [YW-1:0]            ctrl_y,
    output logic [15:0]              ctrl_clear_color,
    output logic                     ctrl_draw,
    output logic                     ctrl_clear,
    input  logic                     gpu_busy,
    output logic [$clog2(DEPTH):0]   queue_level,
    output logic                     idle,
    output logic                     err_timeout
`ifdef GPU_CMDQ_STATS_EN
    ,
    output logic [31:0]              stat_cmds,
    output logic [31:0]              stat_full
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic          op;
        logic [31:0]   address;
        logic [15:0]   address_x;
        logic [15:0]   address_y;
        logic [15:0]   image_width;
        logic [XW-1:0] width;
        logic [YW-1:0] height;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [15:0]   color;
    } entry_t;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_ACK, WAIT_DONE} state_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic          cur_op;
    logic [1:0]    ack_cnt;
    logic          set_err;
    state_t        state, state_nxt;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd.cmd_ready = !full;
    assign push        = cmd.cmd_valid && !full;
    assign pop         = (state == IDLE) && !empty;
    assign queue_level = wr_ptr - rd_ptr;
    assign idle        = empty && (state == IDLE);
    assign head        = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{op:          cmd.cmd_op,
                                     address:     cmd.cmd_address,
                                     address_x:   cmd.cmd_address_x,
                                     address_y:   cmd.cmd_address_y,
                                     image_width: cmd.cmd_image_width,
                                     width:       cmd.cmd_width,
                                     height:      cmd.cmd_height,
                                     x:           cmd.cmd_x,
                                     y:           cmd.cmd_y,
                                     color:       cmd.cmd_color};
        end
    end

    always_comb begin
        state_nxt = state;
        set_err   = 1'b0;
        case (state)
            IDLE:      if (!empty) state_nxt = SETUP;
            SETUP:     state_nxt = STROBE;
            STROBE:    state_nxt = gpu_busy ? WAIT_DONE : WAIT_ACK;
            WAIT_ACK: begin
                if (gpu_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (ack_cnt == 2'd3) begin
                    state_nxt = IDLE;
                    set_err   = 1'b1;
                end
            end
            WAIT_DONE: if (!gpu_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        gpu_enable <= ~reset;
        if (reset) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            cur_op           <= 1'b0;
            ack_cnt          <= '0;
            err_timeout      <= 1'b0;
            ctrl_draw        <= 1'b0;
            ctrl_clear       <= 1'b0;
            ctrl_address     <= '0;
            ctrl_address_x   <= '0;
            ctrl_address_y   <= '0;
            ctrl_image_width <= '0;
            ctrl_width       <= '0;
            ctrl_height      <= '0;
            ctrl_x           <= '0;
            ctrl_y           <= '0;
            ctrl_clear_color <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            // Popping on the load edge frees the slot while the command is still in flight.
            if (pop) begin
                rd_ptr           <= rd_ptr + 1'b1;
                cur_op           <= head.op;
                ctrl_address     <= head.address;
                ctrl_address_x   <= head.address_x;
                ctrl_address_y   <= head.address_y;
                ctrl_image_width <= head.image_width;
                ctrl_width       <= head.width;
                ctrl_height      <= head.height;
                ctrl_x           <= head.x;
                ctrl_y           <= head.y;
                ctrl_clear_color <= head.op ? head.color : 16'h0000;
            end
            ack_cnt    <= (state == WAIT_ACK) ? ack_cnt + 2'd1 : 2'd0;
            ctrl_draw  <= (state_nxt == STROBE) && !cur_op;
            ctrl_clear <= (state_nxt == STROBE) && cur_op;
            if (set_err) err_timeout <= 1'b1;
        end
    end

`ifdef GPU_CMDQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cmds <= '0;
            stat_full <= '0;
        end else begin
            if ((state == WAIT_DONE) && !gpu_busy) stat_cmds <= stat_cmds + 32'd1;
            if (cmd.cmd_valid && full)            stat_full <= stat_full + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Bench for gpu_cmd_queue: scoreboard of accepted commands checked at every strobe, plus directed timing checks.
module tb_gpu_cmd_queue;
    localparam int DEPTH = 8;
    localparam int XW    = 11;
    localparam int YW    = 10;

    typedef struct {
        logic          op;
        logic [31:0]   addr;
        logic [15:0]   ax, ay, iw;
        logic [XW-1:0] w, x;
        logic [YW-1:0] h, y;
        logic [15:0]   color;
    } cmd_t;

    logic clk = 1'b0;
    logic reset, gpu_busy;
    logic gpu_enable, ctrl_draw, ctrl_clear, idle, err_timeout;
    logic [31:0]   ctrl_address;
    logic [15:0]   ctrl_address_x, ctrl_address_y, ctrl_image_width, ctrl_clear_color;
    logic [XW-1:0] ctrl_width, ctrl_x;
    logic [YW-1:0] ctrl_height, ctrl_y;
    logic [3:0]    queue_level;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_len = 0;
    int strobes_seen = 0;
    cmd_t exp_q[$];

    gpu_cmd_queue_if #(.XW(XW), .YW(YW)) cif ();

    gpu_cmd_queue #(.DEPTH(DEPTH), .FB_WIDTH(400), .FB_HEIGHT(240)) dut (
        .clk(clk), .reset(reset), .cmd(cif.slave), .gpu_enable(gpu_enable),
        .ctrl_address(ctrl_address), .ctrl_address_x(ctrl_address_x),
        .ctrl_address_y(ctrl_address_y), .ctrl_image_width(ctrl_image_width),
        .ctrl_width(ctrl_width), .ctrl_height(ctrl_height), .ctrl_x(ctrl_x),
        .ctrl_y(ctrl_y), .ctrl_clear_color(ctrl_clear_color), .ctrl_draw(ctrl_draw),
        .ctrl_clear(ctrl_clear), .gpu_busy(gpu_busy), .queue_level(queue_level),
        .idle(idle), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cmd_t mk(input logic op, input int x, input int y, input int w,
                                input int h, input logic [15:0] color, input int seed);
        cmd_t c;
        c.op = op;
        c.addr = 32'h1000_0000 + 32'(seed) * 32'h100;
        c.ax = 16'(seed * 3);
        c.ay = 16'(seed * 5 + 1);
        c.iw = 16'(320 + seed);
        c.x = XW'(x);
        c.y = YW'(y);
        c.w = XW'(w);
        c.h = YW'(h);
        c.color = color;
        return c;
    endfunction

    task automatic push(input cmd_t c, input int bound);
        bit ok = 0;
        bit r;
        cif.cmd_valid = 1'b1;
        cif.cmd_op = c.op;            cif.cmd_address = c.addr;
        cif.cmd_address_x = c.ax;     cif.cmd_address_y = c.ay;
        cif.cmd_image_width = c.iw;   cif.cmd_width = c.w;
        cif.cmd_height = c.h;         cif.cmd_x = c.x;
        cif.cmd_y = c.y;              cif.cmd_color = c.color;
        for (int i = 0; i < bound && !ok; i++) begin
            r = cif.cmd_ready;
            tick();
            if (r) ok = 1;
        end
        cif.cmd_valid = 1'b0;
        if (ok) exp_q.push_back(c);
        else chk("push_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int bound);
        int i = 0;
        while (!idle && i < bound) begin
            tick();
            i++;
        end
        if (!idle) chk("drain_timeout", 0, 1);
    endtask

    task automatic wait_strobe(input int bound, output int cycles);
        cycles = 0;
        while (!(ctrl_draw || ctrl_clear) && cycles < bound) begin
            tick();
            cycles++;
        end
        if (!(ctrl_draw || ctrl_clear)) chk("strobe_wait_timeout", 0, 1);
    endtask

    // GPU model: raises busy in the strobe cycle and holds it for busy_len cycles.
    initial begin
        int n;
        gpu_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if ((ctrl_draw || ctrl_clear) && busy_len > 0 && !reset) begin
                n = busy_len;
                gpu_busy = 1'b1;
                for (int k = 0; k < n; k++) begin
                    @(posedge clk);
                    #1;
                    if (reset) break;
                end
                gpu_busy = 1'b0;
            end
        end
    end

    // Per-cycle checks against the command scoreboard and the queue rules.
    logic          prev_vld = 1'b0;
    logic          prev_strobe;
    logic [127:0]  prev_fields;
    always @(negedge clk) begin
        logic [127:0] cur_fields;
        cmd_t e;
        cur_fields = {ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width,
                      5'(ctrl_width), 6'(ctrl_height), 5'(ctrl_x), 6'(ctrl_y),
                      ctrl_clear_color};
        if (reset) begin
            prev_vld = 1'b0;
        end else begin
            chk("ready_vs_full", cif.cmd_ready, queue_level != DEPTH);
            chk("level_bound", queue_level <= DEPTH, 1);
            chk("idle_implies_empty", idle && (queue_level != 0), 0);
            if (ctrl_draw || ctrl_clear) begin
                strobes_seen++;
                chk("strobe_onehot", ctrl_draw && ctrl_clear, 0);
                if (prev_vld) begin
                    chk("strobe_after_low", prev_strobe, 0);
                    chk("fields_stable_setup", cur_fields, prev_fields);
                end
                if (exp_q.size() == 0) begin
                    chk("strobe_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_op", ctrl_clear, e.op);
                    chk("sb_addr", ctrl_address, e.addr);
                    chk("sb_addr_x", ctrl_address_x, e.ax);
                    chk("sb_addr_y", ctrl_address_y, e.ay);
                    chk("sb_img_w", ctrl_image_width, e.iw);
                    chk("sb_w", ctrl_width, e.w);
                    chk("sb_h", ctrl_height, e.h);
                    chk("sb_x", ctrl_x, e.x);
                    chk("sb_y", ctrl_y, e.y);
                    chk("sb_color", ctrl_clear_color, e.op ? e.color : 16'h0000);
                end
            end
            prev_vld    = 1'b1;
            prev_strobe = ctrl_draw || ctrl_clear;
            prev_fields = cur_fields;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int cyc;
        reset = 1'b1;
        cif.cmd_valid = 1'b0;
        cif.cmd_op = 1'b0; cif.cmd_address = '0; cif.cmd_address_x = '0;
        cif.cmd_address_y = '0; cif.cmd_image_width = '0; cif.cmd_width = '0;
        cif.cmd_height = '0; cif.cmd_x = '0; cif.cmd_y = '0; cif.cmd_color = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_ctrl_addr", ctrl_address, 0);
        chk("rst_ctrl_x", ctrl_x, 0);
        chk("rst_ctrl_color", ctrl_clear_color, 0);
        chk("rst_strobes", {ctrl_draw, ctrl_clear}, 0);
        chk("rst_ready", cif.cmd_ready, 1);
        chk("rst_level", queue_level, 0);
        chk("rst_idle", idle, 1);
        chk("rst_gpu_enable", gpu_enable, 0);
        chk("rst_err", err_timeout, 0);
        reset = 1'b0;
        tick();
        chk("gpu_enable_after_release", gpu_enable, 1);

        // Single draw: fields at N+1, strobe at N+2, idle after busy falls
        busy_len = 8;
        push(mk(1'b0, 10, 20, 4, 2, 16'h1234, 1), 4);
        chk("t2_level_after_push", queue_level, 1);
        chk("t2_idle_after_push", idle, 0);
        tick();
        chk("t2_setup_x", ctrl_x, 10);
        chk("t2_setup_y", ctrl_y, 20);
        chk("t2_setup_w", ctrl_width, 4);
        chk("t2_setup_h", ctrl_height, 2);
        chk("t2_setup_draw_low", ctrl_draw, 0);
        chk("t2_level_popped", queue_level, 0);
        tick();
        chk("t2_strobe_draw", ctrl_draw, 1);
        chk("t2_strobe_clear", ctrl_clear, 0);
        chk("t2_draw_color_zero", ctrl_clear_color, 0);
        tick();
        chk("t2_draw_one_cycle", ctrl_draw, 0);
        repeat (7) tick();
        chk("t2_busy_still", idle, 0);
        tick();
        chk("t2_idle_after_busy", idle, 1);
        chk("t2_fields_held", ctrl_x, 10);

        // Fill the queue while the GPU is held busy
        busy_len = 40;
        for (int i = 0; i < 9; i++) push(mk(i[0], 30 + i, 40 + i, 8, 8, 16'(16'hA000 + i), 10 + i), 4);
        chk("t3_level_full", queue_level, 8);
        chk("t3_ready_low", cif.cmd_ready, 0);
        chk("t3_idle_low", idle, 0);
        busy_len = 3;
        push(mk(1'b0, 99, 77, 5, 6, 16'h0, 30), 100);
        chk("t3_level_after_stall", queue_level, 8);
        chk("t3_ready_low_again", cif.cmd_ready, 0);
        wait_idle(2000);
        chk("t3_drained_level", queue_level, 0);

        // Draw then clear back to back
        busy_len = 2;
        push(mk(1'b0, 1, 2, 3, 4, 16'h5555, 40), 4);
        push(mk(1'b1, 0, 0, 400, 240, 16'hF801, 41), 4);
        wait_strobe(20, cyc);
        chk("t4_first_is_draw", ctrl_draw, 1);
        tick();
        wait_strobe(20, cyc);
        chk("t4_second_gap", cyc + 1, 5);
        chk("t4_clear_strobe", ctrl_clear, 1);
        chk("t4_clear_color", ctrl_clear_color, 16'hF801);
        chk("t4_no_draw", ctrl_draw, 0);
        wait_idle(100);

        // No acknowledge: timeout flag, then the next command proceeds
        busy_len = 0;
        push(mk(1'b1, 7, 7, 7, 7, 16'h00FF, 50), 4);
        push(mk(1'b0, 8, 8, 8, 8, 16'h0, 51), 4);
        wait_strobe(20, cyc);
        tick();
        busy_len = 2;
        repeat (3) tick();
        chk("t5_err_at_s4", err_timeout, 0);
        tick();
        chk("t5_err_at_s5", err_timeout, 1);
        tick();
        chk("t5_no_strobe_s6", ctrl_draw || ctrl_clear, 0);
        tick();
        chk("t5_next_strobe_s7", ctrl_draw, 1);
        wait_idle(100);
        chk("t5_err_sticky", err_timeout, 1);

        // Reset during WAIT_DONE with three queued
        busy_len = 50;
        for (int i = 0; i < 4; i++) push(mk(1'b0, 60 + i, 61, 2, 2, 16'h0, 60 + i), 4);
        chk("t6_level_pre_reset", queue_level, 3);
        reset = 1'b1;
        tick();
        tick();
        exp_q.delete();
        chk("t6_level_reset", queue_level, 0);
        chk("t6_strobes_reset", {ctrl_draw, ctrl_clear}, 0);
        chk("t6_err_cleared", err_timeout, 0);
        chk("t6_gpu_enable_low", gpu_enable, 0);
        reset = 1'b0;
        strobes_seen = 0;
        tick();
        chk("t6_gpu_enable_back", gpu_enable, 1);
        repeat (20) tick();
        chk("t6_no_strobes", strobes_seen, 0);
        chk("t6_idle", idle, 1);
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
